// File: rtl/rf_exec_pkg.sv
// Shared definitions for the register-file execute sequencer: instruction
// field positions, ALU opcodes and FSM state encoding.
package rf_exec_pkg;

  localparam int INSTR_W = 16;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam int RD_MSB  = 12;
  localparam int RD_LSB  = 10;
  localparam int RS_MSB  = 9;
  localparam int RS_LSB  = 7;
  localparam int RT_MSB  = 6;
  localparam int RT_LSB  = 4;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SLT  = 3'd5;
  localparam logic [2:0] OP_SLL  = 3'd6;
  localparam logic [2:0] OP_ADDI = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_e;

endpackage

// File: rtl/rf_alu.sv
// Combinational 8-op ALU; all arithmetic wraps modulo 2^DATA_W.
module rf_alu
  import rf_exec_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        imm4,
  output logic [DATA_W-1:0] y
);

  logic [DATA_W-1:0] imm_sext;

  assign imm_sext = {{(DATA_W-4){imm4[3]}}, imm4};

  // NOTE: y is assigned before the case so no path through the block can infer a latch.
  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SLT:  y = ($signed(a) < $signed(b)) ? DATA_W'(1) : '0;
      OP_SLL:  y = a << imm4[2:0];
      OP_ADDI: y = a + imm_sext;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rf_exec_sequencer.sv
// Four-cycle IDLE->READ->EXEC->WB sequencer driving an external 8x8 register
// file; one instruction in flight, no pipelining.
module rf_exec_sequencer
  import rf_exec_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  RX,
  output logic [ADDR_W-1:0]  RY,
  input  logic [DATA_W-1:0]  busX,
  input  logic [DATA_W-1:0]  busY,
  output logic [ADDR_W-1:0]  RW,
  output logic               WEN,
  output logic [DATA_W-1:0]  busW,
  output logic               done,
  output logic [DATA_W-1:0]  result,
  output logic [CNT_W-1:0]   retired
);

  state_e              state_q,   state_d;
  logic [INSTR_W-1:0]  instr_q,   instr_d;
  logic [DATA_W-1:0]   op_a_q,    op_a_d;
  logic [DATA_W-1:0]   op_b_q,    op_b_d;
  logic [DATA_W-1:0]   alu_q,     alu_d;
  logic [DATA_W-1:0]   result_q,  result_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic [DATA_W-1:0]   alu_y;

  rf_alu #(.DATA_W(DATA_W)) u_alu (
    .op   (instr_q[OP_MSB:OP_LSB]),
    .a    (op_a_q),
    .b    (op_b_q),
    .imm4 (instr_q[IMM_MSB:IMM_LSB]),
    .y    (alu_y)
  );

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    alu_d     = alu_q;
    result_d  = result_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = S_READ;
        end
      end
      S_READ: begin
        op_a_d  = busX;
        op_b_d  = busY;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_d   = alu_y;
        state_d = S_WB;
      end
      S_WB: begin
        result_d  = alu_q;
        retired_d = retired_q + CNT_W'(1);
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= S_IDLE;
      instr_q   <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      alu_q     <= '0;
      result_q  <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      alu_q     <= alu_d;
      result_q  <= result_d;
      retired_q <= retired_d;
    end
  end

  // Write enable is decoded from the state flop, so reset drops it asynchronously.
  assign instr_ready = (state_q == S_IDLE);
  assign WEN         = (state_q == S_WB);
  assign done        = WEN;
  assign RX          = instr_q[RS_MSB:RS_LSB];
  assign RY          = instr_q[RT_MSB:RT_LSB];
  assign RW          = instr_q[RD_MSB:RD_LSB];
  assign busW        = alu_q;
  assign result      = result_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_rf_exec_sequencer.sv
// Bench: sequencer plus a behavioural 8x8 register file (r0 reads zero),
// checked by a write-back scoreboard and fixed expected register values.
module tb_rf_exec_sequencer;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [2:0]  RX, RY, RW;
  logic [7:0]  busX, busY, busW, result;
  logic        WEN, done;
  logic [15:0] retired;

  logic [7:0]  rf [8];
  logic [7:0]  m_rf [8];

  typedef struct {
    logic [2:0] rd;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int accepts;
  int ready_hi;

  rf_exec_sequencer dut (
    .Clk         (clk),
    .Rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .RX          (RX),
    .RY          (RY),
    .busX        (busX),
    .busY        (busY),
    .RW          (RW),
    .WEN         (WEN),
    .busW        (busW),
    .done        (done),
    .result      (result),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial foreach (rf[i]) rf[i] = 8'h00;
  always @(posedge clk) if (WEN && RW != 3'd0) rf[RW] <= busW;
  assign busX = (RX == 3'd0) ? 8'h00 : rf[RX];
  assign busY = (RY == 3'd0) ? 8'h00 : rf[RY];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  function automatic logic [7:0] alu_model(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic [3:0] imm);
    logic [7:0] s;
    s = {{4{imm[3]}}, imm};
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
      3'd6: return a << imm[2:0];
      default: return a + s;
    endcase
  endfunction

  function automatic void push_expect(input logic [15:0] w);
    exp_t e;
    e.rd  = w[12:10];
    e.val = alu_model(w[15:13], m_rf[w[9:7]], m_rf[w[6:4]], w[3:0]);
    sb.push_back(e);
    if (e.rd != 3'd0) m_rf[e.rd] = e.val;
  endfunction

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic [2:0] rt,
                                      input logic [3:0] imm);
    return {op, rd, rs, rt, imm};
  endfunction

  // Handshake one word; the bound turns a stuck ready into a failure.
  task automatic send(input logic [15:0] w);
    bit ok = 0;
    instr       = w;
    instr_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (instr_ready) ok = 1;
      @(posedge clk);
    end
    if (!ok) check("accept_timeout", instr_ready, 1);
    #1 instr_valid = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [2:0] rt, input logic [3:0] imm);
    logic [15:0] w;
    w = enc(op, rd, rs, rt, imm);
    push_expect(w);
    send(w);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Write-back monitor: every WB cycle must match the oldest expected write.
  logic       res_pending = 1'b0;
  logic [7:0] res_exp;
  always @(negedge clk) begin
    if (rst_n) begin
      if (res_pending) begin
        check("result_hold", result, res_exp);
        res_pending = 1'b0;
      end
      if (WEN) begin
        exp_t e;
        done_cnt++;
        check("wb_done", done, 1);
        if (sb.size() == 0) begin
          check("sb_underflow", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check("wb_rw", RW, e.rd);
          check("wb_busw", busW, e.val);
          res_exp     = e.val;
          res_pending = 1'b1;
        end
      end
    end else begin
      res_pending = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    foreach (m_rf[i]) m_rf[i] = 8'h00;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    #2;
    check("rst_wen", WEN, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_retired", retired, 0);
    check("rst_ports", {RX, RY, RW}, 0);
    check("rst_ready", instr_ready, 1);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: immediates, including a negative one
    issue(3'd7, 3'd1, 3'd0, 3'd0, 4'd5);
    issue(3'd7, 3'd2, 3'd0, 3'd0, 4'hD);
    drain();
    check("t1_r1", rf[1], 8'h05);
    check("t1_r2", rf[2], 8'hFD);
    check("t1_done_cnt", done_cnt, 2);
    check("t1_retired", retired, 2);

    // 2: ADD/SUB with wrap-around
    issue(3'd0, 3'd3, 3'd1, 3'd2, 4'd0);
    issue(3'd1, 3'd4, 3'd2, 3'd1, 4'd0);
    drain();
    check("t2_r3", rf[3], 8'h02);
    check("t2_r4", rf[4], 8'hF8);

    // 3: SLT/SLL/XOR, then AND/OR and SLL ignoring imm4[3]
    issue(3'd5, 3'd5, 3'd2, 3'd1, 4'd0);
    issue(3'd6, 3'd6, 3'd1, 3'd0, 4'd3);
    issue(3'd4, 3'd7, 3'd6, 3'd1, 4'd0);
    drain();
    check("t3_r5", rf[5], 8'h01);
    check("t3_r6", rf[6], 8'h28);
    check("t3_r7", rf[7], 8'h2D);
    issue(3'd2, 3'd5, 3'd7, 3'd6, 4'd0);
    issue(3'd3, 3'd4, 3'd2, 3'd1, 4'd0);
    issue(3'd6, 3'd6, 3'd1, 3'd0, 4'hB);
    drain();
    check("t3_and", rf[5], 8'h28);
    check("t3_or", rf[4], 8'hFD);
    check("t3_sll_b", rf[6], 8'h28);
    check("t3_retired", retired, 10);

    // 4: write to r0 is issued but discarded
    issue(3'd0, 3'd0, 3'd1, 3'd1, 4'd0);
    drain();
    check("t4_result", result, 8'h0A);
    check("t4_r0", rf[0], 8'h00);
    check("t4_retired", retired, 11);

    // 5: valid held high for 12 cycles, ADDI r1,r1,#1 each accept
    accepts  = 0;
    ready_hi = 0;
    instr       = enc(3'd7, 3'd1, 3'd1, 3'd0, 4'd1);
    instr_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (instr_ready) begin
        ready_hi++;
        accepts++;
        push_expect(instr);
      end
      @(posedge clk);
    end
    #1 instr_valid = 1'b0;
    drain();
    check("t5_accepts", accepts, 3);
    check("t5_ready_hi", ready_hi, 3);
    check("t5_r1", rf[1], 8'h08);
    check("t5_retired", retired, 14);

    // 6: reset in EXEC drops the instruction
    instr       = enc(3'd7, 3'd3, 3'd0, 3'd0, 4'd7);
    instr_valid = 1'b1;
    @(negedge clk);
    check("t6_ready", instr_ready, 1);
    @(posedge clk); #1 instr_valid = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("t6_wen", WEN, 0);
    check("t6_retired", retired, 0);
    check("t6_idle", instr_ready, 1);
    check("t6_result", result, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("t6_r3_kept", rf[3], 8'h02);
    check("t6_no_done", done_cnt, 14);
    issue(3'd7, 3'd3, 3'd0, 3'd0, 4'd7);
    drain();
    check("t6_r3_new", rf[3], 8'h07);
    check("t6_retired_after", retired, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
